jht_assoc: RTL
==============

Name: jht_assoc

Overview:
- Parametrised set-associative jump target table; successor of the fixed 4-way JHT.
- Sits beside fetch stage F1: takes the jump PC and returns a registered target prediction one cycle later.
- Trained from EXE by executed j/jal.
- Adds over the previous generation:
  - generic tree-PLRU for any power-of-two associativity
  - explicit init/flush sweep FSM with a ready flag
  - retargeting of existing entries
  - invalid-way-first allocation
  - registered prediction output

Parameters:
ASSOCIATIVITY, 4, ways per set; power of two, >=2
SET_NUM, 8, sets; power of two, >=2
TAG_BITS, 18, tag width, taken from pc[2 +: TAG_BITS]
INDEX_OFFSET, 3, index taken from pc[2+INDEX_OFFSET +: log2(SET_NUM)]

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  invalidate whole table (restarts sweep)
pred_valid  in  1  prediction request this cycle
j_pc  in  32  PC to predict (F1)
pred_hit  out  1  registered: request of previous cycle hit
predict_pc  out  32  registered target; 0 when !pred_hit
upd_valid  in  1  executed j/jal writes table (EXE)
executed_j_pc  in  32  PC of executed jump
dest_pc  in  32  resolved target
ready  out  1  table initialised, accepting requests

Behaviour:
- Storage per set: ASSOCIATIVITY entries of {valid, tag, target[31:0]}, plus ASSOCIATIVITY-1 PLRU bits.
- FSM states: INIT, READY.
  - Reset state: INIT with set counter 0; ready=0, pred_hit=0, predict_pc=0.
  - INIT: one set per cycle; clear all valid bits and PLRU bits of set[counter], then counter+1.
  - After set SET_NUM-1 is cleared, go to READY. ready=1 from the next cycle, i.e. exactly SET_NUM cycles after reset deasserts.
  - READY + flush: back to INIT with counter=0; ready drops the next cycle.
  - flush during INIT: counter restarts at 0.
  - Reset asserted mid-sweep or mid-update: immediate return to INIT; no partial write survives.
- While not READY:
  - pred_hit registers 0.
  - upd_valid is ignored.
  - PLRU is not touched.
- Prediction latency is 1 cycle.
  - pred_valid&ready at edge t: pred_hit/predict_pc at t+1 reflect table contents before edge t's writes.
  - !pred_valid: outputs register 0/0.
  - Hit means valid && tag match; if several ways match, the lowest way index wins.
- Update at edge (upd_valid&ready):
  - Tag hit in way w: target overwritten only if it differs from dest_pc; PLRU touches w.
  - Miss, victim selection: lowest-index invalid way; if none, PLRU victim. Write valid=1, tag, target; touch victim.
- PLRU:
  - Heap-ordered tree; node bit 1 = victim in upper half.
  - Touching way w sets each node on w's path to point away from w.
  - Predict hit touches its way.
  - Predict hit and update in the same set and same cycle: only the update touch applies. Different sets: both apply.
- Predict and update to the same set in one cycle: the prediction sees the old entry (no forwarding).

Optional Feature:
- Macro: JHT_BYPASS_EN.
- Defined: when pred_valid & upd_valid in the same cycle with equal index and tag, the registered output is pred_hit=1, predict_pc=dest_pc. The update proceeds normally.
- Not defined: no forwarding; old-content rule above applies.

Test Plan (ASSOCIATIVITY=4, SET_NUM=8, INDEX_OFFSET=3):
1. Deassert reset, hold pred_valid=1 with j_pc=0x1000 -> ready=0 for 8 cycles, 1 from cycle 8 on; pred_hit=0 throughout.
2. Update 0x1000->0x2000, then predict 0x1000 -> next cycle pred_hit=1, predict_pc=0x2000. Predict 0x1004 -> pred_hit=0, predict_pc=0.
3. Update 0x1000->0x3000 -> predict gives 0x3000. Add 3 more same-set PCs (0x1100, 0x1200, 0x1300) -> all hit, confirming no duplicate way was allocated.
4. Update 0x1000, 0x1100, 0x1200, 0x1300 (ways 0-3), then 0x1400 -> way 0 evicted: 0x1000 misses, the other four hit.
5. Fill entries, pulse flush for 1 cycle -> ready=0 for 8 cycles, then all prior PCs miss. Assert reset mid-sweep -> sweep restarts from set 0.
6. Same cycle: pred_valid with j_pc=0x1000 and upd_valid with 0x1000->0x5000 on an empty table -> next cycle pred_hit=0 without JHT_BYPASS_EN, pred_hit=1 and predict_pc=0x5000 with it; the following predict hits 0x5000 in both builds.

Source files
------------

// File: rtl/jht_assoc.sv
// jht_assoc: parametrised set-associative jump target table.
// Looks up the F1 jump PC and returns a registered target one cycle later.
// It is trained by executed j/jal from EXE.
// Replacement: invalid way first, then tree-PLRU victim.
// After reset or flush an INIT sweep clears one set per cycle, and `ready` rises when the sweep ends.
// Optional macro JHT_BYPASS_EN: a same-cycle update with matching index and tag
// is forwarded to the prediction output.
module jht_assoc #(
  parameter int ASSOCIATIVITY = 4,
  parameter int SET_NUM       = 8,
  parameter int TAG_BITS      = 18,
  parameter int INDEX_OFFSET  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        pred_valid,
  input  logic [31:0] j_pc,
  output logic        pred_hit,
  output logic [31:0] predict_pc,
  input  logic        upd_valid,
  input  logic [31:0] executed_j_pc,
  input  logic [31:0] dest_pc,
  output logic        ready
);

  localparam int IDX_W = $clog2(SET_NUM);
  localparam int WAY_W = $clog2(ASSOCIATIVITY);
  localparam int NODES = ASSOCIATIVITY - 1;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Touch a way: every node on the way's root-to-leaf path points away from it.
  function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                  input logic [WAY_W-1:0] way);
    logic [NODES-1:0] res;
    int node;
    res  = bits;
    node = 1;
    for (int lvl = WAY_W - 1; lvl >= 0; lvl--) begin
      for (int n = 0; n < NODES; n++) begin
        res[n] = (n == node - 1) ? ~way[lvl] : res[n];
      end
      node = 2 * node + (way[lvl] ? 1 : 0);
    end
    return res;
  endfunction

  // Follow node bits from the root; a bit of 1 sends the walk to the upper half.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [NODES-1:0] bits);
    logic [WAY_W-1:0] way;
    logic b;
    int node;
    way  = '0;
    node = 1;
    for (int lvl = WAY_W - 1; lvl >= 0; lvl--) begin
      b = 1'b0;
      for (int n = 0; n < NODES; n++) begin
        b = (n == node - 1) ? bits[n] : b;
      end
      way[lvl] = b;
      node = 2 * node + (b ? 1 : 0);
    end
    return way;
  endfunction

  // Lowest set bit index; callers only use the result when the vector is non-zero.
  function automatic logic [WAY_W-1:0] lowest_way(input logic [ASSOCIATIVITY-1:0] vec);
    logic [WAY_W-1:0] way;
    way = '0;
    for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
      way = vec[w] ? WAY_W'(w) : way;
    end
    return way;
  endfunction

  // Table storage
  logic [ASSOCIATIVITY-1:0] valid_r  [SET_NUM];
  logic [NODES-1:0]         plru_r   [SET_NUM];
  logic [TAG_BITS-1:0]      tag_r    [SET_NUM][ASSOCIATIVITY];
  logic [31:0]              target_r [SET_NUM][ASSOCIATIVITY];

  state_t                   state_r, state_n;
  logic [IDX_W-1:0]         cnt_r, cnt_n;
  logic                     pred_hit_r;
  logic [31:0]              predict_pc_r;

  // Lookup / update decode
  logic [IDX_W-1:0]         pred_idx_s, upd_idx_s;
  logic [TAG_BITS-1:0]      pred_tag_s, upd_tag_s;
  logic [ASSOCIATIVITY-1:0] pred_match_s, upd_match_s;
  logic                     pred_hit_s, upd_hit_s, upd_any_inv_s;
  logic [WAY_W-1:0]         pred_way_s, upd_way_s;
  logic [31:0]              pred_tgt_s;
  logic                     upd_en_s, upd_wr_tgt_s, pred_touch_s;
  logic                     unused_pc_bits_s;

  assign ready      = (state_r == ST_READY);
  assign pred_hit   = pred_hit_r;
  assign predict_pc = predict_pc_r;
  // Not every PC bit feeds the tag or the index.
  assign unused_pc_bits_s = ^{j_pc, executed_j_pc};

  // Next-state logic of the init/flush sweep
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    case (state_r)
      ST_INIT: begin
        if (flush) begin
          cnt_n = '0;
        end else if (cnt_r == IDX_W'(SET_NUM - 1)) begin
          state_n = ST_READY;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_r + IDX_W'(1);
        end
      end
      ST_READY: begin
        if (flush) begin
          state_n = ST_INIT;
          cnt_n   = '0;
        end else begin
          state_n = ST_READY;
          cnt_n   = cnt_r;
        end
      end
      default: begin
        state_n = ST_INIT;
        cnt_n   = '0;
      end
    endcase
  end

  // Prediction lookup: lowest matching way wins
  always_comb begin
    pred_idx_s = j_pc[2 + INDEX_OFFSET +: IDX_W];
    pred_tag_s = j_pc[2 +: TAG_BITS];
    for (int w = 0; w < ASSOCIATIVITY; w++) begin
      pred_match_s[w] = valid_r[pred_idx_s][w] && (tag_r[pred_idx_s][w] == pred_tag_s);
    end
    pred_hit_s   = |pred_match_s;
    pred_way_s   = lowest_way(pred_match_s);
    pred_tgt_s   = pred_hit_s ? target_r[pred_idx_s][pred_way_s] : 32'h0000_0000;
    pred_touch_s = pred_valid && ready && pred_hit_s;
  end

  // Update way selection: tag hit, else lowest invalid, else PLRU victim
  always_comb begin
    upd_idx_s = executed_j_pc[2 + INDEX_OFFSET +: IDX_W];
    upd_tag_s = executed_j_pc[2 +: TAG_BITS];
    for (int w = 0; w < ASSOCIATIVITY; w++) begin
      upd_match_s[w] = valid_r[upd_idx_s][w] && (tag_r[upd_idx_s][w] == upd_tag_s);
    end
    upd_hit_s     = |upd_match_s;
    upd_any_inv_s = ~&valid_r[upd_idx_s];
    if (upd_hit_s) begin
      upd_way_s = lowest_way(upd_match_s);
    end else if (upd_any_inv_s) begin
      upd_way_s = lowest_way(~valid_r[upd_idx_s]);
    end else begin
      upd_way_s = plru_victim(plru_r[upd_idx_s]);
    end
    upd_en_s     = upd_valid && ready;
    upd_wr_tgt_s = upd_en_s && (!upd_hit_s || (target_r[upd_idx_s][upd_way_s] != dest_pc));
  end

`ifdef JHT_BYPASS_EN
  logic bypass_s;
  assign bypass_s = pred_valid && upd_valid && ready &&
                    (pred_idx_s == upd_idx_s) && (pred_tag_s == upd_tag_s);
`endif

  // Sweep state and set counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_INIT;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  // Valid and PLRU bits: cleared by the sweep, updated by training and prediction hits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SET_NUM; s++) begin
        valid_r[s] <= '0;
        plru_r[s]  <= '0;
      end
    end else if (state_r == ST_INIT) begin
      valid_r[cnt_r] <= '0;
      plru_r[cnt_r]  <= '0;
    end else begin
      for (int s = 0; s < SET_NUM; s++) begin
        if (upd_en_s && (upd_idx_s == IDX_W'(s))) begin
          plru_r[s] <= plru_touch(plru_r[s], upd_way_s);
        end else if (pred_touch_s && (pred_idx_s == IDX_W'(s))) begin
          plru_r[s] <= plru_touch(plru_r[s], pred_way_s);
        end else begin
          plru_r[s] <= plru_r[s];
        end
      end
      if (upd_en_s) begin
        valid_r[upd_idx_s][upd_way_s] <= 1'b1;
      end else begin
        valid_r[upd_idx_s][upd_way_s] <= valid_r[upd_idx_s][upd_way_s];
      end
    end
  end

  // Tag and target payload; stale contents are masked by the valid bits
  always_ff @(posedge clk) begin
    if (upd_en_s && !upd_hit_s) begin
      tag_r[upd_idx_s][upd_way_s] <= upd_tag_s;
    end
    if (upd_wr_tgt_s) begin
      target_r[upd_idx_s][upd_way_s] <= dest_pc;
    end
  end

  // Registered prediction outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_hit_r   <= 1'b0;
      predict_pc_r <= 32'h0000_0000;
    end else if (pred_valid && ready) begin
`ifdef JHT_BYPASS_EN
      if (bypass_s) begin
        pred_hit_r   <= 1'b1;
        predict_pc_r <= dest_pc;
      end else begin
        pred_hit_r   <= pred_hit_s;
        predict_pc_r <= pred_tgt_s;
      end
`else
      pred_hit_r   <= pred_hit_s;
      predict_pc_r <= pred_tgt_s;
`endif
    end else begin
      pred_hit_r   <= 1'b0;
      predict_pc_r <= 32'h0000_0000;
    end
  end

endmodule
